// File: rtl/popcount_pkg.sv
// Shared constants and sizing helpers for the pipelined population counter.
package popcount_pkg;

  localparam int unsigned LEAF_W = 4;

  // Number of pairwise-add tree levels: ceil-log2 of the 4-bit group count.
  function automatic int unsigned stage_count(int unsigned width);
    int unsigned groups;
    groups = (width + LEAF_W - 1) / LEAF_W;
    return $clog2(groups);
  endfunction

  function automatic int unsigned stage_width(int unsigned idx);
    return 3 + idx;
  endfunction

  function automatic logic [2:0] leaf_count(logic [LEAF_W-1:0] grp);
    return {2'b00, grp[0]} + {2'b00, grp[1]} + {2'b00, grp[2]} + {2'b00, grp[3]};
  endfunction

endpackage

// File: rtl/popcount_stage.sv
// One registered pairwise-add level of the popcount tree, with valid/last tags
// and a hold enable used for backpressure.
module popcount_stage
  import popcount_pkg::*;
#(
  parameter int unsigned N_IN = 2,
  parameter int unsigned IN_W = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic [N_IN*IN_W-1:0]          in_data,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [(N_IN/2)*(IN_W+1)-1:0]  out_data
);

  localparam int unsigned N_OUT = N_IN / 2;
  localparam int unsigned OUT_W = IN_W + 1;

  logic [N_OUT*OUT_W-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < N_OUT; k++) begin
      sum_d[k*OUT_W +: OUT_W] = OUT_W'(in_data[(2*k)*IN_W +: IN_W])
                              + OUT_W'(in_data[(2*k+1)*IN_W +: IN_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_last  <= in_last;
      out_data  <= sum_d;
    end
  end

endmodule

// File: rtl/popcount_pipe.sv
// Pipelined population counter with valid/ready backpressure. Define
// POPCOUNT_PIPE_ACCUM_EN to sum counts per packet (delimited by in_last).
module popcount_pipe
  import popcount_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_sat
);

  localparam int unsigned T     = stage_count(WIDTH);
  localparam int unsigned NG    = 1 << T;
  localparam int unsigned P     = NG * LEAF_W;
  localparam int unsigned CW    = stage_width(T);
  localparam int unsigned BUS_W = NG * 3;

  logic stall, en, accept;

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // Leaf stage
  logic [P-1:0]     padded;
  logic [BUS_W-1:0] leaf_d, leaf_q;
  logic             leaf_valid_q, leaf_last_q;

  assign padded = P'(in_data);

  always_comb begin
    leaf_d = '0;
    for (int g = 0; g < NG; g++) begin
      leaf_d[g*3 +: 3] = leaf_count(padded[g*LEAF_W +: LEAF_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leaf_valid_q <= 1'b0;
      leaf_last_q  <= 1'b0;
      leaf_q       <= '0;
    end else if (en) begin
      leaf_valid_q <= accept;
      if (accept) begin
        leaf_q      <= leaf_d;
        leaf_last_q <= in_last;
      end
    end
  end

  // Tree levels share one bus width; narrower levels leave upper bits at zero.
  wire [T:0]       lvl_valid;
  wire [T:0]       lvl_last;
  wire [BUS_W-1:0] lvl_data [T+1];

  assign lvl_valid[0] = leaf_valid_q;
  assign lvl_last[0]  = leaf_last_q;
  assign lvl_data[0]  = leaf_q;

  for (genvar i = 0; i < T; i++) begin : g_tree
    localparam int unsigned NIN   = NG >> i;
    localparam int unsigned IW    = stage_width(i);
    localparam int unsigned IBITS = NIN * IW;
    localparam int unsigned OBITS = (NIN / 2) * (IW + 1);

    popcount_stage #(
      .N_IN (NIN),
      .IN_W (IW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (lvl_valid[i]),
      .in_last   (lvl_last[i]),
      .in_data   (lvl_data[i][IBITS-1:0]),
      .out_valid (lvl_valid[i+1]),
      .out_last  (lvl_last[i+1]),
      .out_data  (lvl_data[i+1][OBITS-1:0])
    );

    if (OBITS < BUS_W) begin : g_pad
      assign lvl_data[i+1][BUS_W-1:OBITS] = '0;
    end
  end

  logic [CW-1:0] cnt;
  assign cnt = lvl_data[T][CW-1:0];

`ifdef POPCOUNT_PIPE_ACCUM_EN
  logic [ACC_W-1:0] acc_q, acc_d, base;
  logic [ACC_W:0]   sum_w;
  logic             sat_q, sat_d, start_q, ovf;

  always_comb begin
    base  = start_q ? '0 : acc_q;
    sum_w = {1'b0, base} + (ACC_W+1)'(cnt);
    ovf   = sum_w[ACC_W];
    acc_d = ovf ? '1 : sum_w[ACC_W-1:0];
    sat_d = (~start_q & sat_q) | ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_sat   <= 1'b0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      start_q   <= 1'b1;
    end else if (en) begin
      out_valid <= lvl_valid[T] & lvl_last[T];
      if (lvl_valid[T]) begin
        acc_q   <= acc_d;
        sat_q   <= sat_d;
        start_q <= lvl_last[T];
        if (lvl_last[T]) begin
          out_count <= acc_d;
          out_sat   <= sat_d;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_count <= '0;
    end else if (en) begin
      out_valid <= lvl_valid[T];
      if (lvl_valid[T]) begin
        out_count <= ACC_W'(cnt);
      end
    end
  end

  assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_popcount_pipe.sv
// Directed self-checking bench for popcount_pipe: 32-bit, 13-bit and 8-bit-accumulator instances.
module tb_popcount_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;
  logic        v_main, v_odd, v_acc;

  logic        m_in_ready, m_out_valid, m_out_sat;
  logic [15:0] m_out_count;
  logic        o_in_ready, o_out_valid, o_out_sat;
  logic [7:0]  o_out_count;
  logic        a_in_ready, a_out_valid, a_out_sat;
  logic [7:0]  a_out_count;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          o_cnt = 0;
  int          m_q[$];
  int unsigned m_cq[$];
  int          a_q[$];
  int          a_sq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  popcount_pipe #(.WIDTH(32), .ACC_W(16)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(v_main), .in_ready(m_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_count(m_out_count), .out_sat(m_out_sat)
  );

  popcount_pipe #(.WIDTH(13), .ACC_W(8)) u_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(v_odd), .in_ready(o_in_ready),
    .in_data(in_data[12:0]), .in_last(in_last), .out_valid(o_out_valid),
    .out_ready(out_ready), .out_count(o_out_count), .out_sat(o_out_sat)
  );

  popcount_pipe #(.WIDTH(32), .ACC_W(8)) u_acc (
    .clk(clk), .rst_n(rst_n), .in_valid(v_acc), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_count(a_out_count), .out_sat(a_out_sat)
  );

  always @(negedge clk) begin
    if (m_out_valid && out_ready) begin
      m_q.push_back(int'(m_out_count));
      m_cq.push_back(cyc);
    end
    if (o_out_valid && out_ready) o_cnt++;
    if (a_out_valid && out_ready) begin
      a_q.push_back(int'(a_out_count));
      a_sq.push_back(int'(a_out_sat));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  // Presents one word, then counts edges until the result appears.
  task automatic send_single(input int which, input logic [31:0] d, input int exp_cnt,
                             input int exp_lat, input string tag);
    int   n;
    logic got_v;
    in_data   = d;
    in_last   = 1'b1;
    out_ready = 1'b1;
    if (which == 0) v_main = 1'b1;
    else            v_odd  = 1'b1;
    @(posedge clk); #1;
    v_main = 1'b0;
    v_odd  = 1'b0;
    n      = 1;
    got_v  = (which == 0) ? m_out_valid : o_out_valid;
    while (!got_v && n < 20) begin
      @(posedge clk); #1;
      n++;
      got_v = (which == 0) ? m_out_valid : o_out_valid;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " count"}, (which == 0) ? 32'(m_out_count) : 32'(o_out_count), exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] all_ones;
    int          wi, lows;
    int unsigned t0;
    int          bp_exp[8] = '{32, 28, 24, 20, 16, 12, 8, 4};

    rst_n = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    v_main = 1'b0; v_odd = 1'b0; v_acc = 1'b0;
    all_ones = 32'hFFFF_FFFF;

    #12;
    check("rst out_valid", m_out_valid, 0);
    check("rst out_count", m_out_count, 0);
    check("rst out_sat",   m_out_sat, 0);
    check("rst in_ready",  m_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    check("no spurious out_valid", m_q.size(), 0);

    send_single(0, 32'hFFFF_FFFF, 32, 5, "ones");
    send_single(0, 32'h0000_0000, 0, 5, "zeros");
    send_single(0, 32'h8000_0001, 2, 5, "ends");
    check("single out_sat", m_out_sat, 0);
    repeat (3) begin @(posedge clk); #1; end

    // Streaming 1, 3, 7, ... 0xFF
    m_q.delete(); m_cq.delete();
    w = '0;
    t0 = 0;
    for (int i = 0; i < 8; i++) begin
      w = (w << 1) | 32'h1;
      in_data = w; in_last = 1'b1; v_main = 1'b1;
      @(posedge clk); #1;
      if (i == 0) t0 = cyc;
    end
    v_main = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("stream results", m_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("stream count %0d", i), qget(m_q, i), i + 1);
    end
    check("stream consecutive", (m_cq.size() == 8) ? m_cq[7] - m_cq[0] : 0, 7);
    // Result becomes visible four edges after the transfer edge.
    check("stream first latency", (m_cq.size() > 0) ? m_cq[0] - t0 : 0, 4);

    // Backpressure: out_ready low in loop cycles 6..8
    m_q.delete();
    wi = 0; lows = 0;
    for (int j = 0; j < 24; j++) begin
      out_ready = !(j >= 6 && j <= 8);
      v_main    = (wi < 8);
      in_data   = all_ones >> (4 * wi);
      in_last   = 1'b1;
      #1;
      if (j >= 6 && j <= 8) begin
        check($sformatf("bp in_ready c%0d", j), m_in_ready, 0);
        check($sformatf("bp hold c%0d", j), m_out_count, 28);
      end else if (!m_in_ready) begin
        lows++;
      end
      if (v_main && m_in_ready) wi++;
      @(posedge clk); #1;
    end
    v_main = 1'b0;
    out_ready = 1'b1;
    check("bp stray in_ready low", lows, 0);
    check("bp results", m_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp order %0d", i), qget(m_q, i), bp_exp[i]);
    end

    // Accumulation: 9 all-ones words then single-word packet 0xF
    a_q.delete(); a_sq.delete();
    for (int i = 0; i < 9; i++) begin
      in_data = 32'hFFFF_FFFF; in_last = (i == 8); v_acc = 1'b1;
      @(posedge clk); #1;
    end
    in_data = 32'h0000_000F; in_last = 1'b1;
    @(posedge clk); #1;
    v_acc = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
`ifdef POPCOUNT_PIPE_ACCUM_EN
    check("acc results", a_q.size(), 2);
    check("acc sum", qget(a_q, 0), 255);
    check("acc sat", qget(a_sq, 0), 1);
    check("acc next sum", qget(a_q, 1), 4);
    check("acc next sat", qget(a_sq, 1), 0);
`else
    check("acc results", a_q.size(), 10);
    check("acc first", qget(a_q, 0), 32);
    check("acc first sat", qget(a_sq, 0), 0);
    check("acc last", qget(a_q, 9), 4);
    check("acc last sat", qget(a_sq, 9), 0);
`endif

    // Odd width, then reset mid-stream
    send_single(1, 32'h0000_1FFF, 13, 4, "odd13");
    repeat (3) begin @(posedge clk); #1; end
    o_cnt = 0;
    w = '0;
    for (int i = 0; i < 5; i++) begin
      w = (w << 1) | 32'h1;
      in_data = w; in_last = 1'b1; v_odd = 1'b1;
      @(posedge clk); #1;
    end
    v_odd = 1'b0;
    check("odd pre-reset valid", o_out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("odd rst out_valid", o_out_valid, 0);
    check("odd rst out_count", o_out_count, 0);
    check("odd rst out_sat",   o_out_sat, 0);
    check("odd rst in_ready",  o_in_ready, 1);
    check("odd emitted before rst", o_cnt, 1);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("odd flushed words", o_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/popcount_pipe.md
# popcount_pipe

Parametrised, pipelined population counter. It counts the bits set to 1 in each accepted WIDTH-bit word and returns the count through a valid/ready stream with full backpressure. It replaces the fixed 32-bit combinational counter in datapaths that need arbitrary widths, registered timing closure and optional per-packet accumulation. It sits between a word-stream producer and any consumer of bit-density statistics.

## Interface
- WIDTH, 32: input word width, ≥1.
- ACC_W, 16: width of out_count, ≥ $clog2(WIDTH+1).
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  word to count.
- in_last  input  1  last word of a packet; used only with accumulation.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_count  output  ACC_W  bit count, zero-extended.
- out_sat  output  1  the packet sum saturated; always 0 without accumulation.

## Operation
- Transfer occurs when valid and ready are both high in the same cycle. in_data and in_last are sampled only on a transfer.
- in_data is zero-padded to P = 4·2^T bits, with T = $clog2(ceil(WIDTH/4)).
- Leaf stage: each 4-bit group is counted into a 3-bit value and registered.
- Tree stages: T registered stages, each adding adjacent pairs. Result widths grow by 1 bit per stage, so there is no overflow.
- Output stage: a register holding out_count, out_sat and out_valid.
- Each stage carries a valid bit, and bubbles propagate.
- Stall: stall = out_valid & ~out_ready. While stall is high, every stage holds its contents, including valid bits and the accumulator.
- in_ready = ~stall. This is combinational from out_ready and out_valid.
- Ordering: results leave strictly in acceptance order, with no loss and no duplication.
- Arithmetic: all sums are unsigned. A per-word count can never exceed WIDTH.

## Timing
- Latency: L = T + 2 cycles from the in_data transfer to out_valid, with no stall. For WIDTH=32, L=5. For WIDTH≤4, L=2.
- Throughput: one word per cycle while out_ready stays high.
- Reset, including assertion mid-operation:
  - All stage valid bits clear immediately.
  - out_valid=0, out_count=0, out_sat=0.
  - The accumulator clears and the packet-start flag is set to 1.
  - in_ready reads 1 during and after reset.
  - Partial packets are discarded.
- out_count and out_sat stay stable while out_valid=1 and out_ready=0.
- If in_valid and a stall occur in the same cycle, no transfer happens.

## Configuration
- Macro: POPCOUNT_PIPE_ACCUM_EN.
- Macro defined, packet accumulation:
  - The output stage keeps a running sum acc. For each arriving word: acc ← (start ? 0 : acc) + count. The sum saturates at 2^ACC_W−1 and sets a sticky sat flag.
  - out_valid rises only for the word carrying in_last. out_count = acc, out_sat = sat.
  - Non-last words update acc and raise no out_valid.
  - start is set after a last word and cleared by any non-last word. A single-word packet (in_last on its first word) is legal.
- Macro undefined:
  - Every word produces one result.
  - in_last is ignored and out_sat is tied to 0.
  - No accumulator logic is present.

## Structure
- Shared package popcount_pkg:
  - LEAF_W = 4.
  - A stage-count function, ceil-log2 of the group count.
  - A stage-width function (3 + stage index).
- Sub-module popcount_stage: one registered pairwise-add level, parametrised by input count and width, with a valid bit and a hold-on-stall enable. The top instantiates it T times in a generate loop.

## Test plan
- Reset check: with rst_n low, confirm out_valid=0, out_count=0, out_sat=0, in_ready=1. Release reset and confirm no spurious out_valid.
- Single words at WIDTH=32, each producing a result exactly 5 cycles after its transfer:
  - 32'hFFFF_FFFF → 32.
  - 32'h0000_0000 → 0.
  - 32'h8000_0001 → 2.
- Streaming: 8 back-to-back words 32'h1, 32'h3, …, 32'hFF with out_ready=1 → counts 1..8 on 8 consecutive cycles, starting at cycle 5.
- Backpressure: stream 8 words and drop out_ready for 3 cycles mid-stream.
  - in_ready=0 for exactly those cycles.
  - out_count holds during the stall.
  - All 8 results arrive in order, with no drops and no duplicates.
- Accumulation (macro on, ACC_W=8):
  - 9 words of all-ones with in_last on the 9th → a single result, out_count=255, out_sat=1.
  - The next packet, one word 32'hF with in_last → out_count=4, out_sat=0.
- Odd width (WIDTH=13, L=4): 13'h1FFF → 13. Then assert rst_n mid-stream → outputs clear asynchronously, and words in flight are never emitted.
